// File: rtl/apb_timer_regbank_if.sv
// APB3 bus bundle for the timer register bank.
interface apb_timer_regbank_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_timer_regbank.sv
// APB3 register bank for NUM_CH timer channels: TDR/TCR per channel, sticky W1C status,
// per-channel interrupts and programmable access wait states.
module apb_timer_ch #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_tdr,
  input  logic              i_wr_tcr,
  input  logic              i_wr_tsr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ovf,
  input  logic              i_udf,
  output logic [DATA_W-1:0] o_tdr,
  output logic [DATA_W-1:0] o_tcr,
  output logic [DATA_W-1:0] o_tsr,
  output logic              o_tdr_load,
  output logic              o_irq
);
  logic [DATA_W-1:0] r_tdr, r_tcr;
  logic [1:0]        r_tsr;
  logic              r_tdr_load;
  logic [1:0]        w_clr;

  assign w_clr = i_wr_tsr ? i_wdata[1:0] : 2'b00;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tdr      <= '0;
      r_tcr      <= '0;
      r_tsr      <= '0;
      r_tdr_load <= 1'b0;
    end else begin
      if (i_wr_tdr) r_tdr <= i_wdata;
      if (i_wr_tcr) r_tcr <= i_wdata;
      // clear first, then OR in events so a same-cycle event survives the W1C
      r_tsr      <= (r_tsr & ~w_clr) | {i_udf, i_ovf};
      r_tdr_load <= i_wr_tdr;
    end
  end

  assign o_tdr      = r_tdr;
  assign o_tcr      = r_tcr;
  assign o_tsr      = DATA_W'(r_tsr);
  assign o_tdr_load = r_tdr_load;
  assign o_irq      = |(r_tsr & r_tcr[1:0]);
endmodule

module apb_timer_regbank #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  apb_timer_regbank_if.slave         apb,
  input  logic [NUM_CH-1:0]          tmr_ovf,
  input  logic [NUM_CH-1:0]          tmr_udf,
  output logic [NUM_CH*DATA_W-1:0]   tdr,
  output logic [NUM_CH*DATA_W-1:0]   tcr,
  output logic [NUM_CH-1:0]          tdr_load,
  output logic [NUM_CH-1:0]          irq,
  output logic                       irq_any
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [ADDR_W:0] MAP_END  = (ADDR_W+1)'(4*NUM_CH);
  localparam logic [3:0]      WAIT_MAX = 4'(WAIT_CYCLES);

  state_t                          r_state, w_nxt;
  logic [3:0]                      r_cnt;
  logic                            w_ready, w_valid, w_wr;
  logic [ADDR_W-1:0]               w_word;
  logic [DATA_W-1:0]               w_rd_reg;
  logic [NUM_CH-1:0][DATA_W-1:0]   w_tdr, w_tcr, w_tsr;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == SETUP)                          r_cnt <= '0;
      else if (r_state == ACCESS && r_cnt < WAIT_MAX) r_cnt <= r_cnt + 4'd1;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (apb.PSEL && !apb.PENABLE) w_nxt = SETUP;
      SETUP:   w_nxt = ACCESS;
      ACCESS:  if (w_ready || !apb.PSEL) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready     = (r_state == ACCESS) && apb.PSEL && apb.PENABLE && (r_cnt == WAIT_MAX);
    apb.PREADY  = w_ready;
    apb.PSLVERR = w_ready && !w_valid;
    apb.PRDATA  = (w_ready && !apb.PWRITE && w_valid) ? w_rd_reg : '0;
  end

  // offset 3 of each channel is reserved and decodes as an error
  assign w_valid = ({1'b0, apb.PADDR} < MAP_END) && (apb.PADDR[1:0] != 2'd3);
  assign w_word  = apb.PADDR >> 2;
  assign w_wr    = w_ready && apb.PWRITE && w_valid;

  always_comb begin
    w_rd_reg = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_word == ADDR_W'(c)) begin
        case (apb.PADDR[1:0])
          2'd0:    w_rd_reg = w_tdr[c];
          2'd1:    w_rd_reg = w_tcr[c];
          2'd2:    w_rd_reg = w_tsr[c];
          default: w_rd_reg = '0;
        endcase
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_hit;
    assign w_hit = w_wr && (w_word == ADDR_W'(c));
    apb_timer_ch #(.DATA_W(DATA_W)) u_ch (
      .i_clk      (PCLK),
      .i_rst      (PRESET),
      .i_wr_tdr   (w_hit && apb.PADDR[1:0] == 2'd0),
      .i_wr_tcr   (w_hit && apb.PADDR[1:0] == 2'd1),
      .i_wr_tsr   (w_hit && apb.PADDR[1:0] == 2'd2),
      .i_wdata    (apb.PWDATA),
      .i_ovf      (tmr_ovf[c]),
      .i_udf      (tmr_udf[c]),
      .o_tdr      (w_tdr[c]),
      .o_tcr      (w_tcr[c]),
      .o_tsr      (w_tsr[c]),
      .o_tdr_load (tdr_load[c]),
      .o_irq      (irq[c])
    );
  end

  assign tdr     = w_tdr;
  assign tcr     = w_tcr;
  assign irq_any = |irq;
endmodule

// File: tb/tb_apb_timer_regbank.sv
// Randomised and directed bench for apb_timer_regbank against an address-map level model.
module tb_apb_timer_regbank;
  localparam int NCH = 2, DW = 8, AW = 5, WAIT = 2;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic [NCH-1:0]    tmr_ovf = '0, tmr_udf = '0;
  logic [NCH*DW-1:0] tdr, tcr;
  logic [NCH-1:0]    tdr_load, irq;
  logic              irq_any;

  apb_timer_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_timer_regbank #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WAIT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus), .tmr_ovf(tmr_ovf), .tmr_udf(tmr_udf),
    .tdr(tdr), .tcr(tcr), .tdr_load(tdr_load), .irq(irq), .irq_any(irq_any)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0, n_bad = 0;

  // reference model: register file seen through the address map
  logic [7:0] m_tdr [NCH];
  logic [7:0] m_tcr [NCH];
  logic [1:0] m_tsr [NCH];

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin m_tdr[c] = 0; m_tcr[c] = 0; m_tsr[c] = 0; end
  endfunction
  function automatic bit m_valid(int a);
    return (a < 4*NCH) && ((a % 4) != 3);
  endfunction
  function automatic logic [7:0] m_rd(int a);
    if (!m_valid(a)) return 8'h00;
    case (a % 4)
      0:       return m_tdr[a/4];
      1:       return m_tcr[a/4];
      default: return {6'b0, m_tsr[a/4]};
    endcase
  endfunction
  function automatic void m_wr(int a, logic [7:0] d);
    if (!m_valid(a)) return;
    case (a % 4)
      0:       m_tdr[a/4] = d;
      1:       m_tcr[a/4] = d;
      default: m_tsr[a/4] = m_tsr[a/4] & ~d[1:0];
    endcase
  endfunction
  function automatic logic [NCH-1:0] m_irq();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = |(m_tsr[c] & m_tcr[c][1:0]);
    return r;
  endfunction
  function automatic logic [NCH*DW-1:0] m_pack(bit which_tcr);
    logic [NCH*DW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*DW +: DW] = which_tcr ? m_tcr[c] : m_tdr[c];
    return r;
  endfunction

  // one APB transfer; ovf_hit is driven on the cycle PREADY is seen so it lands on the commit edge
  task automatic apb_xfer(input bit wr, input int a, input logic [7:0] d, input logic [NCH-1:0] ovf_hit,
                          output logic [7:0] rd, output logic err, output int lat);
    bit ok;
    ok = 0;
    @(negedge PCLK);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = wr; bus.PADDR = AW'(a); bus.PWDATA = d;
    @(negedge PCLK);
    bus.PENABLE = 1; lat = 0; rd = 'x; err = 1'bx;
    while (!ok && lat < 20) begin
      @(negedge PCLK); lat++;
      if (bus.PREADY) begin ok = 1; rd = bus.PRDATA; err = bus.PSLVERR; tmr_ovf = ovf_hit; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL handshake: no PREADY within %0d cycles, addr %0d", lat, a); end
    @(negedge PCLK);
    bus.PSEL = 0; bus.PENABLE = 0; tmr_ovf = '0;
  endtask

  task automatic pulse_evt(input logic [NCH-1:0] ovf, input logic [NCH-1:0] udf);
    @(negedge PCLK); tmr_ovf = ovf; tmr_udf = udf;
    @(negedge PCLK); tmr_ovf = '0; tmr_udf = '0;
    for (int c = 0; c < NCH; c++) m_tsr[c] = m_tsr[c] | {udf[c], ovf[c]};
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic err; int lat;
    @(negedge PCLK);
    n_cmp++; if ({bus.PREADY, bus.PSLVERR, bus.PRDATA, tdr_load, irq, irq_any, tdr, tcr} !== '0) begin
      n_bad++; $display("FAIL reset_hold: outputs %h required 0", {bus.PREADY, bus.PSLVERR, bus.PRDATA, tdr_load, irq, irq_any, tdr, tcr}); end
    PRESET = 0; m_reset();
    apb_xfer(1, 0, 8'h77, '0, rd, err, lat); m_wr(0, 8'h77);
    apb_xfer(1, 1, 8'h03, '0, rd, err, lat); m_wr(1, 8'h03);
    pulse_evt(2'b01, 2'b00);
    n_cmp++; if (irq !== 2'b01 || tdr[7:0] !== 8'h77) begin
      n_bad++; $display("FAIL pre_reset: irq %b tdr0 %h required 01 77", irq, tdr[7:0]); end
    // start a TDR0 write and reset while in the wait states
    @(negedge PCLK); bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 0; bus.PWDATA = 8'h99;
    @(negedge PCLK); bus.PENABLE = 1;
    @(negedge PCLK); #1 PRESET = 1; #1;
    n_cmp++; if ({bus.PREADY, bus.PSLVERR, bus.PRDATA, tdr_load, irq, irq_any, tdr, tcr} !== '0) begin
      n_bad++; $display("FAIL reset_mid: outputs %h required 0", {bus.PREADY, bus.PSLVERR, bus.PRDATA, tdr_load, irq, irq_any, tdr, tcr}); end
    bus.PSEL = 0; bus.PENABLE = 0;
    @(negedge PCLK); PRESET = 0; m_reset();
    apb_xfer(0, 0, 8'h00, '0, rd, err, lat);
    n_cmp++; if (rd !== 8'h00 || err !== 1'b0) begin
      n_bad++; $display("FAIL reset_read: prdata %h pslverr %b required 00 0", rd, err); end
  endtask

  task automatic test_rw_wait();
    logic [7:0] rd; logic err; int lat;
    apb_xfer(1, 5, 8'hA5, '0, rd, err, lat); m_wr(5, 8'hA5);
    n_cmp++; if (lat !== WAIT+1 || err !== 1'b0 || tdr_load !== '0) begin
      n_bad++; $display("FAIL rw_write: lat %0d err %b load %b required %0d 0 00", lat, err, tdr_load, WAIT+1); end
    apb_xfer(0, 5, 8'h00, '0, rd, err, lat);
    n_cmp++; if (rd !== 8'hA5 || lat !== WAIT+1 || err !== 1'b0) begin
      n_bad++; $display("FAIL rw_read: prdata %h lat %0d required A5 %0d", rd, lat, WAIT+1); end
  endtask

  task automatic test_tdr_load();
    logic [7:0] rd; logic err; int lat;
    apb_xfer(1, 0, 8'h3C, '0, rd, err, lat); m_wr(0, 8'h3C);
    n_cmp++; if (tdr[7:0] !== 8'h3C || tdr_load !== 2'b01) begin
      n_bad++; $display("FAIL tdr_load_hi: tdr0 %h load %b required 3C 01", tdr[7:0], tdr_load); end
    @(negedge PCLK);
    n_cmp++; if (tdr_load !== 2'b00) begin
      n_bad++; $display("FAIL tdr_load_lo: load %b required 00", tdr_load); end
  endtask

  task automatic test_flags_irq();
    logic [7:0] rd; logic err; int lat;
    apb_xfer(1, 1, 8'h01, '0, rd, err, lat); m_wr(1, 8'h01);
    pulse_evt(2'b01, 2'b00);
    apb_xfer(0, 2, 8'h00, '0, rd, err, lat);
    n_cmp++; if (rd !== 8'h01 || irq[0] !== 1'b1 || irq_any !== 1'b1) begin
      n_bad++; $display("FAIL flag_ovf: tsr0 %h irq %b any %b required 01 1 1", rd, irq[0], irq_any); end
    pulse_evt(2'b00, 2'b01);
    apb_xfer(0, 2, 8'h00, '0, rd, err, lat);
    n_cmp++; if (rd !== 8'h03 || irq[0] !== 1'b1) begin
      n_bad++; $display("FAIL flag_udf: tsr0 %h irq0 %b required 03 1", rd, irq[0]); end
    apb_xfer(1, 2, 8'h01, '0, rd, err, lat); m_wr(2, 8'h01);
    apb_xfer(0, 2, 8'h00, '0, rd, err, lat);
    n_cmp++; if (rd !== 8'h02 || irq[0] !== 1'b0) begin
      n_bad++; $display("FAIL flag_w1c: tsr0 %h irq0 %b required 02 0", rd, irq[0]); end
  endtask

  task automatic test_collision();
    logic [7:0] rd; logic err; int lat;
    pulse_evt(2'b10, 2'b00);
    apb_xfer(1, 6, 8'h01, 2'b10, rd, err, lat); m_wr(6, 8'h01); m_tsr[1] = m_tsr[1] | 2'b01;
    apb_xfer(0, 6, 8'h00, '0, rd, err, lat);
    n_cmp++; if (rd !== 8'h01 || irq !== m_irq()) begin
      n_bad++; $display("FAIL collision: tsr1 %h irq %b required 01 %b", rd, irq, m_irq()); end
    apb_xfer(1, 6, 8'h01, '0, rd, err, lat); m_wr(6, 8'h01);
    apb_xfer(0, 6, 8'h00, '0, rd, err, lat);
    n_cmp++; if (rd !== 8'h00) begin
      n_bad++; $display("FAIL clear_after: tsr1 %h required 00", rd); end
  endtask

  task automatic test_errors();
    logic [7:0] rd; logic err; int lat; bit seen;
    int bad_addr[3] = '{3, 8, 15};
    foreach (bad_addr[i]) begin
      apb_xfer(0, bad_addr[i], 8'h00, '0, rd, err, lat);
      n_cmp++; if (err !== 1'b1 || rd !== 8'h00) begin
        n_bad++; $display("FAIL err_read: addr %0d pslverr %b prdata %h required 1 00", bad_addr[i], err, rd); end
    end
    apb_xfer(1, 3, 8'hFF, '0, rd, err, lat);
    n_cmp++; if (err !== 1'b1 || tdr !== m_pack(0) || tcr !== m_pack(1) || tdr_load !== '0) begin
      n_bad++; $display("FAIL err_write: err %b tdr %h tcr %h required 1 %h %h", err, tdr, tcr, m_pack(0), m_pack(1)); end
    // PSEL dropped in the wait states: no write, next transfer has normal latency
    seen = 0;
    @(negedge PCLK); bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 4; bus.PWDATA = 8'hEE;
    @(negedge PCLK); bus.PENABLE = 1;
    repeat (2) begin @(negedge PCLK); seen |= bus.PREADY; end
    bus.PSEL = 0; bus.PENABLE = 0;
    repeat (2) @(negedge PCLK);
    n_cmp++; if (seen || tdr !== m_pack(0)) begin
      n_bad++; $display("FAIL abort: pready_seen %b tdr %h required 0 %h", seen, tdr, m_pack(0)); end
    apb_xfer(0, 4, 8'h00, '0, rd, err, lat);
    n_cmp++; if (rd !== m_tdr[1] || lat !== WAIT+1) begin
      n_bad++; $display("FAIL after_abort: prdata %h lat %0d required %h %0d", rd, lat, m_tdr[1], WAIT+1); end
  endtask

  task automatic test_random();
    logic [7:0] rd, d; logic err; int lat, a; bit wr;
    logic [NCH-1:0] hit, exp_ld;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) pulse_evt(NCH'($urandom), NCH'($urandom));
      a = $urandom_range(0, 11); wr = 1'($urandom); d = 8'($urandom);
      hit = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      exp_ld = (wr && m_valid(a) && (a % 4) == 0) ? NCH'(1 << (a / 4)) : '0;
      apb_xfer(wr, a, d, hit, rd, err, lat);
      if (wr) begin
        m_wr(a, d);
        for (int c = 0; c < NCH; c++) m_tsr[c] = m_tsr[c] | {1'b0, hit[c]};
        n_cmp++; if (err !== !m_valid(a) || tdr !== m_pack(0) || tcr !== m_pack(1) || tdr_load !== exp_ld || irq !== m_irq()) begin
          n_bad++; $display("FAIL rand_wr %0d: addr %0d err %b tdr %h tcr %h ld %b irq %b required %b %h %h %b %b",
                            i, a, err, tdr, tcr, tdr_load, irq, !m_valid(a), m_pack(0), m_pack(1), exp_ld, m_irq()); end
      end else begin
        n_cmp++; if (rd !== m_rd(a) || err !== !m_valid(a) || irq_any !== |m_irq()) begin
          n_bad++; $display("FAIL rand_rd %0d: addr %0d prdata %h err %b any %b required %h %b %b",
                            i, a, rd, err, irq_any, m_rd(a), !m_valid(a), |m_irq()); end
        for (int c = 0; c < NCH; c++) m_tsr[c] = m_tsr[c] | {1'b0, hit[c]};
      end
    end
  endtask

  initial begin
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
    m_reset();
    test_reset();
    test_rw_wait();
    test_tdr_load();
    test_flags_irq();
    test_collision();
    test_errors();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
